// File: rtl/lights_out_button_conditioner.sv
// Button front end for the 3x3 lights-out core: sync, debounce, press arbitration.
// Optional move counter enabled by defining LIGHTS_OUT_MOVE_COUNT_EN.
module lights_out_button_conditioner #(
  parameter int N_BUTTONS       = 9,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] press_onehot,
  output logic                 press_valid,
  output logic [N_BUTTONS-1:0] btn_stable,
`ifdef LIGHTS_OUT_MOVE_COUNT_EN
  input  logic                 clear_moves,
  output logic [7:0]           move_count,
`endif
  output logic                 busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE,
    WAIT_RELEASE
  } state_e;

  logic [N_BUTTONS-1:0] sync_q [SYNC_STAGES];
  logic [N_BUTTONS-1:0] sync;
  logic [CW-1:0]        cnt_q [N_BUTTONS];
  logic [CW-1:0]        cnt_d [N_BUTTONS];
  logic [N_BUTTONS-1:0] stable_q;
  logic [N_BUTTONS-1:0] stable_d;
  logic [N_BUTTONS-1:0] press_q;
  logic                 valid_q;
  logic                 onehot;
  state_e               state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= btn_raw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Flip only after DEBOUNCE_CYCLES consecutive mismatching samples.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N_BUTTONS; i++) begin
      cnt_d[i] = '0;
      if (sync[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= '0;
      for (int i = 0; i < N_BUTTONS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < N_BUTTONS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign onehot = (stable_q != '0) &&
                  ((stable_q & (stable_q - N_BUTTONS'(1))) == '0);

  // Any non-zero level seen from IDLE arms WAIT_RELEASE; only one-hot fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      press_q <= '0;
      valid_q <= 1'b0;
    end else if (!enable) begin
      state_q <= WAIT_RELEASE;
      press_q <= '0;
      valid_q <= 1'b0;
    end else begin
      press_q <= '0;
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (stable_q != '0) begin
            state_q <= WAIT_RELEASE;
            if (onehot) begin
              press_q <= stable_q;
              valid_q <= 1'b1;
            end
          end
        end
        WAIT_RELEASE: begin
          if (stable_q == '0) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign press_onehot = press_q;
  assign press_valid  = valid_q;
  assign btn_stable   = stable_q;
  assign busy         = (state_q == WAIT_RELEASE);

`ifdef LIGHTS_OUT_MOVE_COUNT_EN
  logic [7:0] moves_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      moves_q <= '0;
    end else if (clear_moves) begin
      moves_q <= '0;
    end else if (valid_q && moves_q != 8'hFF) begin
      moves_q <= moves_q + 8'd1;
    end
  end

  assign move_count = moves_q;
`endif

endmodule

// File: tb/tb_lights_out_button_conditioner.sv
// Directed and random bench for lights_out_button_conditioner.
// Reference model works on sample histories rather than counters.
module tb_lights_out_button_conditioner;

  localparam int N  = 9;
  localparam int SS = 2;
  localparam int DC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [N-1:0] btn_raw;
  logic [N-1:0] press_onehot;
  logic         press_valid;
  logic [N-1:0] btn_stable;
  logic         busy;
`ifdef LIGHTS_OUT_MOVE_COUNT_EN
  logic         clear_moves;
  logic [7:0]   move_count;
`endif

  lights_out_button_conditioner #(
    .N_BUTTONS      (N),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .btn_raw     (btn_raw),
    .press_onehot(press_onehot),
    .press_valid (press_valid),
    .btn_stable  (btn_stable),
`ifdef LIGHTS_OUT_MOVE_COUNT_EN
    .clear_moves (clear_moves),
    .move_count  (move_count),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  // model state
  logic [N-1:0] raw_log  [$];
  logic [N-1:0] sync_log [$];
  logic [N-1:0] m_stable;
  logic [N-1:0] m_pulse;
  bit           m_armed;
  int           m_moves;

  // directed-scenario observations
  int           edge_no;
  int           pulse_cnt;
  logic [N-1:0] pulse_val;
  int           pulse_edge;
  int           busy_low_edge;
  int           s0_flips;
  logic         s0_prev;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    raw_log.delete();
    sync_log.delete();
    m_stable = '0;
    m_pulse  = '0;
    m_armed  = 1'b1;
    m_moves  = 0;
  endtask

  task automatic clr_obs();
    edge_no       = 0;
    pulse_cnt     = 0;
    pulse_val     = '0;
    pulse_edge    = 0;
    busy_low_edge = 0;
    s0_flips      = 0;
    s0_prev       = btn_stable[0];
  endtask

  task automatic step();
    logic [N-1:0] n_pulse;
    logic [N-1:0] n_stable;
    logic [N-1:0] s_in;
    bit           n_armed;
    bit           all_diff;
    int           sz;
    int           n_moves;
    n_pulse  = '0;
    n_stable = m_stable;
    n_armed  = m_armed;
    n_moves  = m_moves;
    if (rst) begin
      raw_log.delete();
      sync_log.delete();
      n_stable = '0;
      n_armed  = 1'b1;
      n_moves  = 0;
    end else begin
      if (!enable) n_armed = 1'b0;
      else if (m_armed) begin
        if (m_stable != '0) begin
          n_armed = 1'b0;
          if ($countones(m_stable) == 1) n_pulse = m_stable;
        end
      end else n_armed = (m_stable == '0);
`ifdef LIGHTS_OUT_MOVE_COUNT_EN
      if (clear_moves) n_moves = 0;
      else if (m_pulse != '0 && m_moves < 255) n_moves = m_moves + 1;
`endif
      raw_log.push_back(btn_raw);
      sz = raw_log.size();
      s_in = (sz > SS) ? raw_log[sz-1-SS] : '0;
      sync_log.push_back(s_in);
      sz = sync_log.size();
      if (sz >= DC) begin
        for (int i = 0; i < N; i++) begin
          all_diff = 1'b1;
          for (int j = 0; j < DC; j++)
            if (sync_log[sz-1-j][i] == m_stable[i]) all_diff = 1'b0;
          if (all_diff) n_stable[i] = ~m_stable[i];
        end
      end
    end
    @(posedge clk);
    #1;
    m_stable = n_stable;
    m_pulse  = n_pulse;
    m_armed  = n_armed;
    m_moves  = n_moves;
    edge_no++;
    chk("press_onehot", 32'(press_onehot), 32'(m_pulse));
    chk("press_valid", 32'(press_valid), 32'(m_pulse != '0));
    chk("btn_stable", 32'(btn_stable), 32'(m_stable));
    chk("busy", 32'(busy), 32'(!m_armed));
`ifdef LIGHTS_OUT_MOVE_COUNT_EN
    chk("move_count", 32'(move_count), 32'(m_moves));
`endif
    if (press_valid) begin
      pulse_cnt++;
      pulse_val  = press_onehot;
      pulse_edge = edge_no;
    end
    if (!busy && busy_low_edge == 0) busy_low_edge = edge_no;
    if (btn_stable[0] != s0_prev) s0_flips++;
    s0_prev = btn_stable[0];
  endtask

  task automatic hold(logic [N-1:0] v, int n);
    btn_raw = v;
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    rst     = 1'b1;
    enable  = 1'b0;
    btn_raw = '0;
`ifdef LIGHTS_OUT_MOVE_COUNT_EN
    clear_moves = 1'b0;
`endif
    model_reset();
    step();
    step();
    rst    = 1'b0;
    enable = 1'b1;
    hold('0, 4);

    // mid-operation asynchronous reset
    hold(9'h010, 6);
    chk("pre_rst_stable", 32'(btn_stable), 32'h010);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_stable", 32'(btn_stable), 32'h0);
    chk("rst_async_press", 32'(press_onehot), 32'h0);
    chk("rst_async_valid", 32'(press_valid), 32'h0);
    chk("rst_async_busy", 32'(busy), 32'h0);
    model_reset();
    hold('0, 2);
    rst = 1'b0;
    hold('0, 5);
    chk("post_rst_outs", 32'({btn_stable, press_onehot, press_valid, busy}), 32'h0);

    // clean press, release timing, re-press
    clr_obs();
    hold(9'h010, 20);
    chk("clean_cnt", 32'(pulse_cnt), 32'd1);
    chk("clean_val", 32'(pulse_val), 32'h010);
    chk("clean_edge", 32'(pulse_edge), 32'd7);
    clr_obs();
    hold('0, 12);
    chk("release_busy_low_edge", 32'(busy_low_edge), 32'd7);
    clr_obs();
    hold(9'h010, 10);
    chk("repress_cnt", 32'(pulse_cnt), 32'd1);
    hold('0, 10);

    // bounce on bit 0
    clr_obs();
    for (int k = 0; k < 6; k++) hold((k % 2 == 0) ? 9'h001 : 9'h000, 2);
    hold(9'h001, 12);
    chk("bounce_flips", 32'(s0_flips), 32'd1);
    chk("bounce_cnt", 32'(pulse_cnt), 32'd1);
    chk("bounce_val", 32'(pulse_val), 32'h001);
    hold('0, 10);
    clr_obs();
    for (int g = 1; g <= 3; g++) begin
      hold(9'h001, g);
      hold('0, 8);
    end
    chk("glitch_cnt", 32'(pulse_cnt), 32'd0);
    chk("glitch_flips", 32'(s0_flips), 32'd0);

    // chord rejection
    clr_obs();
    hold(9'h003, 10);
    chk("chord_cnt", 32'(pulse_cnt), 32'd0);
    chk("chord_busy", 32'(busy), 32'd1);
    hold(9'h001, 10);
    chk("chord_partial_cnt", 32'(pulse_cnt), 32'd0);
    hold('0, 10);
    hold(9'h001, 10);
    chk("chord_after_cnt", 32'(pulse_cnt), 32'd1);
    chk("chord_after_val", 32'(pulse_val), 32'h001);
    hold('0, 10);

    // held across enable rise
    clr_obs();
    enable = 1'b0;
    hold(9'h100, 10);
    enable = 1'b1;
    hold(9'h100, 10);
    chk("en_held_cnt", 32'(pulse_cnt), 32'd0);
    hold('0, 10);
    hold(9'h100, 10);
    chk("en_repress_cnt", 32'(pulse_cnt), 32'd1);
    chk("en_repress_val", 32'(pulse_val), 32'h100);
    hold('0, 10);

    // random segments against the model
    for (int s = 0; s < 250; s++) begin
      logic [N-1:0] v;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 4) v = '0;
      else if (sel < 8) v = N'(1) << $urandom_range(0, N - 1);
      else v = N'($urandom);
      enable = ($urandom_range(0, 9) != 0);
      hold(v, int'($urandom_range(1, 8)));
    end
    enable = 1'b1;
    hold('0, 10);

`ifdef LIGHTS_OUT_MOVE_COUNT_EN
    rst = 1'b1;
    model_reset();
    hold('0, 1);
    rst = 1'b0;
    hold('0, 2);
    for (int p = 0; p < 257; p++) begin
      hold(9'h001, 8);
      hold('0, 8);
    end
    chk("moves_sat", 32'(move_count), 32'd255);
    hold(9'h001, 7);
    chk("clr_press_valid", 32'(press_valid), 32'd1);
    clear_moves = 1'b1;
    step();
    clear_moves = 1'b0;
    chk("moves_cleared", 32'(move_count), 32'd0);
    hold('0, 10);
`endif

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
